qspi_ddr_oserdes: RTL
=====================

// Module: qspi_ddr_oserdes
//
// PURPOSE
//  Parametrised DDR output serializer for the QSPI flash controllers; the
//  multi-lane successor to our single-pin DDR output cell.
//  Accepts words over a valid/ready handshake and shifts them MSB-first onto
//  1, 2 or 4 data lanes, two bits per lane per i_clk, with a DDR-generated
//  SCK and per-lane output enables.
//  Sits between the flash command/data FSM and the I/O pads.
//
// PARAMETERS
//  NLANES    4     data lanes instantiated; legal values 1, 2, 4
//  WORD_W    8     bits per accepted word; must be a multiple of 2*NLANES
//  SCK_IDLE  1'b1  SCK level driven on both halves while idle
//
// PORTS
//  i_clk      in   1           single clock; all logic on posedge
//  i_reset_n  in   1           asynchronous, active-low reset
//  i_stb      in   1           word valid
//  o_ready    out  1           word accepted on i_stb && o_ready
//  i_word     in   WORD_W      data, MSB first
//  i_mode     in   2           lane mode: 0 = 1 lane, 1 = 2 lanes, 2 = 4 lanes
//  i_oe       in   1           drive active lanes for this word; 0 = dummy/turnaround
//  o_done     out  1           one-cycle pulse when the final pair of a word issues
//  o_sck      out  1           DDR SCK pin
//  o_dat      out  NLANES      DDR data pins
//  o_oe       out  NLANES      per-lane output enable, aligned with o_dat
//
// BEHAVIOUR
//  - Reset (async assert, sync release): o_ready=0, o_done=0, shift/count=0,
//    pin pairs SCK={SCK_IDLE,SCK_IDLE}, DAT={0,0}, OE=0. o_ready rises on the
//    first posedge after release.
//  - Lanes L = 1<<i_mode. A mode with L>NLANES, or i_mode=3, is treated as 1 lane.
//  - i_mode and i_oe are sampled only on accept and held for the whole word.
//  - Cycles per word C = WORD_W/(2*L). Each active cycle issues one pair per lane:
//    * first half (D1) carries the next L bits;
//    * second half (D2) carries the following L bits;
//    * lane L-1 carries the most-significant bit of each group.
//    Example, quad, 0xA5: D1=4'hA, D2=4'h5.
//  - SCK pair is {0,1} on active cycles and {SCK_IDLE,SCK_IDLE} otherwise.
//  - OE: o_oe[k] = i_oe && k<L during active cycles, 0 when idle. Data pairs on
//    lanes with k>=L are {0,0}.
//  - States: IDLE -> SHIFT on accept; SHIFT -> IDLE after C cycles, unless a
//    new word is accepted on the final cycle.
//    * o_ready = IDLE || (SHIFT && count==1). This gives back-to-back words with
//      no bubble and no idle SCK pair in between.
//  - o_done is asserted in the same cycle the final pair is registered into the
//    cells, including back-to-back words.
//  - Latency: the first pair reaches the cell inputs on the posedge after
//    accept. The cells add one register stage, identical for SCK, DAT and OE,
//    so all pins stay mutually aligned.
//  - Reset asserted mid-word: the word is dropped, no o_done, and pins go to
//    idle values immediately.
//  - i_stb while !o_ready: the word is ignored; the source must hold it.
//
// STRUCTURE
//  - Shared package (qspi_pkg): mode encodings, LANES_OF(mode) function, and
//    SCK active/idle pair constants.
//  - Sub-module ddr_out_cell(i_clk, i_reset_n, i_d[1:0], o_pin). It registers
//    both halves and drives a vendor ODDR (SAME_EDGE, D1 first). It is
//    instantiated NLANES*2+1 times: data, OE and SCK.
//  - The sim/formal build swaps in a behavioural ODDR model: pin = D1 while
//    clk high, D2 while clk low.
//
// TESTING
//  1. Reset release, i_stb=0 -> o_ready=1 on the 1st edge; SCK pair {1,1};
//     o_oe=0; o_done never pulses.
//  2. Quad, i_oe=1, word 0xA5 -> 1 cycle: D1=4'hA, D2=4'h5, SCK {0,1},
//     o_oe=4'hF, o_done pulse.
//  3. Dual 0xA5 -> 2 cycles of lane[1:0] pairs: (10,10), then (01,01);
//     o_oe=4'h3; lanes 3:2 stay {0,0}.
//  4. Single 0xA5 then 0x3C back-to-back (i_stb held) -> 8 consecutive SCK
//     {0,1} pairs with no idle gap; lane0 bits 10100101_00111100; o_done at
//     cycles 4 and 8.
//  5. Quad 0xFF with i_oe=0 -> SCK toggles for 1 cycle and o_oe=0 throughout.
//  6. i_reset_n low at cycle 2 of a single-mode word -> pins idle immediately,
//     no o_done, o_ready=1 on the 1st edge after release. Repeat with i_mode=3
//     to confirm 1-lane fallback.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI flash controller datapath: lane-mode
// encodings, lane-count decode and the SCK pin-pair patterns.
package qspi_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_DUAL   = 2'd1,
    MODE_QUAD   = 2'd2,
    MODE_RSVD   = 2'd3
  } qspi_mode_e;

  // Pairs are {D1, D2}: D1 is shown while the clock is high, D2 while low.
  localparam logic [1:0] SCK_PAIR_ACTIVE  = 2'b01;
  localparam logic [1:0] SCK_PAIR_IDLE_HI = 2'b11;
  localparam logic [1:0] SCK_PAIR_IDLE_LO = 2'b00;

  // Reserved modes, and modes wider than the instantiated lanes, fall back to 1 lane.
  function automatic logic [2:0] LANES_OF(input logic [1:0] mode, input int unsigned nlanes);
    logic [2:0] lanes;
    case (mode)
      MODE_DUAL: lanes = 3'd2;
      MODE_QUAD: lanes = 3'd4;
      default:   lanes = 3'd1;
    endcase
    if (32'(lanes) > nlanes) lanes = 3'd1;
    return lanes;
  endfunction

endpackage

// File: rtl/ddr_out_cell.sv
// DDR output cell: registers both halves of a pin pair on posedge and presents
// D1 during the high phase and D2 during the low phase of the clock.
module ddr_out_cell #(
  parameter logic [1:0] RST_PAIR = 2'b00
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_d,
  output logic       o_pin
);

  logic [1:0] pair_q, pair_d;

  assign pair_d = i_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) pair_q <= RST_PAIR;
    else            pair_q <= pair_d;
  end

  assign o_pin = i_clk ? pair_q[1] : pair_q[0];

endmodule

// File: rtl/qspi_ddr_oserdes.sv
// Multi-lane DDR output serializer: accepts words on a valid/ready handshake and
// shifts them MSB-first onto 1, 2 or 4 lanes with a DDR-generated SCK.
module qspi_ddr_oserdes
  import qspi_pkg::*;
#(
  parameter int unsigned NLANES   = 4,
  parameter int unsigned WORD_W   = 8,
  parameter logic        SCK_IDLE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_stb,
  output logic              o_ready,
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_mode,
  input  logic              i_oe,
  output logic              o_done,
  output logic              o_sck,
  output logic [NLANES-1:0] o_dat,
  output logic [NLANES-1:0] o_oe
);

  localparam int unsigned CNT_W = $clog2(WORD_W / 2 + 1);
  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_SHIFT = 1'b1;
  localparam logic [1:0]  SCK_PAIR_IDLE = SCK_IDLE ? SCK_PAIR_IDLE_HI : SCK_PAIR_IDLE_LO;

  logic [0:0]        state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        lanes_q, lanes_d;
  logic              oe_q, oe_d;
  logic              live_q, live_d;

  logic              accept, last, active;
  int unsigned       nl;
  logic [NLANES-1:0] lane_mask, d1, d2, oe_lanes;
  logic [1:0]        sck_pair;
  logic [NLANES-1:0][1:0] dat_pair, oe_pair;

  assign active  = (state_q == ST_SHIFT);
  assign last    = active && (count_q == CNT_W'(1));
  assign o_ready = live_q && (!active || last);
  assign o_done  = last;
  assign accept  = i_stb && o_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    lanes_d = lanes_q;
    oe_d    = oe_q;
    live_d  = 1'b1;
    if (active) begin
      shift_d = shift_q << (2 * nl);
      count_d = count_q - CNT_W'(1);
      if (last) state_d = ST_IDLE;
    end
    if (accept) begin
      state_d = ST_SHIFT;
      shift_d = i_word;
      lanes_d = LANES_OF(i_mode, NLANES);
      oe_d    = i_oe;
      case (lanes_d)
        3'd4:    count_d = CNT_W'(WORD_W / 8);
        3'd2:    count_d = CNT_W'(WORD_W / 4);
        default: count_d = CNT_W'(WORD_W / 2);
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      count_q <= '0;
      lanes_q <= 3'd1;
      oe_q    <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      lanes_q <= lanes_d;
      oe_q    <= oe_d;
      live_q  <= live_d;
    end
  end

  // The top 2*L bits of the shifter hold the current pair: the upper L go out
  // as D1, the lower L as D2, with lane L-1 carrying each group's MSB.
  always_comb begin
    nl        = 32'(lanes_q);
    lane_mask = NLANES'((32'd1 << nl) - 32'd1);
    d1        = NLANES'(shift_q >> (WORD_W - nl)) & lane_mask;
    d2        = NLANES'(shift_q >> (WORD_W - 2 * nl)) & lane_mask;
    oe_lanes  = (active && oe_q) ? lane_mask : '0;
    sck_pair  = active ? SCK_PAIR_ACTIVE : SCK_PAIR_IDLE;
    for (int unsigned k = 0; k < NLANES; k++) begin
      dat_pair[k] = active ? {d1[k], d2[k]} : 2'b00;
      oe_pair[k]  = {2{oe_lanes[k]}};
    end
  end

  ddr_out_cell #(.RST_PAIR(SCK_PAIR_IDLE)) u_sck_cell (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (sck_pair),
    .o_pin     (o_sck)
  );

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    ddr_out_cell #(.RST_PAIR(2'b00)) u_dat_cell (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_d       (dat_pair[g]),
      .o_pin     (o_dat[g])
    );
    ddr_out_cell #(.RST_PAIR(2'b00)) u_oe_cell (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_d       (oe_pair[g]),
      .o_pin     (o_oe[g])
    );
  end

endmodule
